button_conditioner: RTL and testbench

//  Front end for the blackJackController button inputs. Synchronises, debounces and
//  (optionally) mutually excludes the raw active-low deal/hit/stand push-buttons.

---
 rtl/button_conditioner.sv | 143 ++++++++++++++
 tb/tb_button_conditioner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Synchronises and debounces the active-low deal/hit/stand buttons, with optional
// single-owner lockout selected by the BUTTON_LOCKOUT_EN macro.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_n_raw,
  input  logic       hit_n_raw,
  input  logic       stand_n_raw,
  output logic       deal,
  output logic       hit,
  output logic       stand,
  output logic [2:0] press_pulse,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: [0]=deal, [1]=hit, [2]=stand.
  logic [2:0]       raw_s;
  logic [2:0]       s1_q, s1_d;
  logic [2:0]       s2_q, s2_d;
  logic [2:0]       stable_q, stable_d;
  logic [2:0]       out_q, out_d;
  logic [2:0]       pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  assign raw_s = {stand_n_raw, hit_n_raw, deal_n_raw};

  // Synchroniser and debouncer next state
  always_comb begin
    s1_d     = raw_s;
    s2_d     = s1_q;
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

`ifdef BUTTON_LOCKOUT_EN
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_DEAL  = 2'd1,
    OWN_HIT   = 2'd2,
    OWN_STAND = 2'd3
  } owner_e;

  owner_e     owner_q, owner_d;
  logic [2:0] mask_q, mask_d;
  logic [2:0] fall_s;
  logic [2:0] own_s;

  // Owner FSM next state; a masked button stays masked until its level releases
  always_comb begin
    fall_s  = stable_q & ~stable_d;
    owner_d = owner_q;
    case (owner_q)
      OWN_NONE: begin
        if (fall_s[0]) begin
          owner_d = OWN_DEAL;
        end else if (fall_s[2]) begin
          owner_d = OWN_STAND;
        end else if (fall_s[1]) begin
          owner_d = OWN_HIT;
        end else begin
          owner_d = OWN_NONE;
        end
      end
      OWN_DEAL:  owner_d = stable_d[0] ? OWN_NONE : OWN_DEAL;
      OWN_HIT:   owner_d = stable_d[1] ? OWN_NONE : OWN_HIT;
      OWN_STAND: owner_d = stable_d[2] ? OWN_NONE : OWN_STAND;
      default:   owner_d = OWN_NONE;
    endcase
    own_s  = {owner_d == OWN_STAND, owner_d == OWN_HIT, owner_d == OWN_DEAL};
    mask_d = (mask_q | (fall_s & ~own_s)) & ~stable_d;
    out_d  = stable_d | mask_d;
  end

  // Owner and mask registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
      mask_q  <= 3'b000;
    end else begin
      owner_q <= owner_d;
      mask_q  <= mask_d;
    end
  end
`else
  // Without lockout every debounced level is forwarded independently
  always_comb begin
    out_d = stable_d;
  end
`endif

  // Strobe on the edge where a forwarded level goes from released to pressed
  always_comb begin
    pulse_d = out_q & ~out_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= 3'b111;
      s2_q     <= 3'b111;
      stable_q <= 3'b111;
      out_q    <= 3'b111;
      pulse_q  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      out_q    <= out_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign deal        = out_q[0];
  assign hit         = out_q[1];
  assign stand       = out_q[2];
  assign press_pulse = pulse_q;
  assign busy        = (cnt_q[0] != CNT_ZERO) | (cnt_q[1] != CNT_ZERO) |
                       (cnt_q[2] != CNT_ZERO);

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: vector table, directed corner cases and
// randomized stimulus against a sliding-window reference model.
module tb_button_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw;
  logic       deal, hit, stand, busy;
  logic [2:0] press_pulse;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk         (clk),
    .rst         (rst),
    .deal_n_raw  (raw[0]),
    .hit_n_raw   (raw[1]),
    .stand_n_raw (raw[2]),
    .deal        (deal),
    .hit         (hit),
    .stand       (stand),
    .press_pulse (press_pulse),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: hist[i][j] is the raw sample taken j edges ago.
  logic [7:0] hist [3];
  logic [2:0] m_stable, m_out, m_pulse, m_mask;
  logic       m_busy;
  int         owner;

  typedef struct {
    logic [2:0] raw;
    logic [2:0] out;
    logic [2:0] pulse;
    logic       busy;
  } vec_t;
  vec_t tbl [18];

  int n_low, n_low2, first_fall, n_pulse, n_pulse2, saw_busy;
  logic [2:0] p_at, r_rand;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = 8'hFF;
    m_stable = 3'b111;
    m_out    = 3'b111;
    m_pulse  = 3'b000;
    m_mask   = 3'b000;
    m_busy   = 1'b0;
    owner    = -1;
  endtask

  // A level is accepted once the D synchronised samples ending two edges ago all differ from it.
  task automatic model_edge(input logic [2:0] r);
    logic [2:0] prev_stable, prev_out, fell;
    logic       all_diff;
    prev_stable = m_stable;
    prev_out    = m_out;
    m_busy      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hist[i]  = {hist[i][6:0], r[i]};
      all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++) begin
        if (hist[i][j] == m_stable[i]) all_diff = 1'b0;
      end
      if (all_diff) m_stable[i] = ~m_stable[i];
      if (hist[i][2] != m_stable[i]) m_busy = 1'b1;
    end
    fell = prev_stable & ~m_stable;
`ifdef BUTTON_LOCKOUT_EN
    if (owner < 0) begin
      if (fell[0]) owner = 0;
      else if (fell[2]) owner = 2;
      else if (fell[1]) owner = 1;
    end else if (m_stable[owner]) begin
      owner = -1;
    end
    for (int i = 0; i < 3; i++) begin
      if (m_stable[i]) m_mask[i] = 1'b0;
      else if (fell[i] && owner != i) m_mask[i] = 1'b1;
    end
    m_out = m_stable | m_mask;
`else
    m_out = m_stable;
`endif
    m_pulse = prev_out & ~m_out;
  endtask

  // Entered at a falling edge: drive, take one rising edge, compare, return at the next falling edge.
  task automatic step(input logic [2:0] r);
    raw = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check("model_out", {stand, hit, deal}, m_out);
    check("model_pulse", press_pulse, m_pulse);
    check("model_busy", busy, m_busy);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{3'b101, 3'b111, 3'b000, 1'b0};
    tbl[1]  = '{3'b101, 3'b111, 3'b000, 1'b0};
    tbl[2]  = '{3'b101, 3'b111, 3'b000, 1'b1};
    tbl[3]  = '{3'b101, 3'b111, 3'b000, 1'b1};
    tbl[4]  = '{3'b101, 3'b111, 3'b000, 1'b1};
    tbl[5]  = '{3'b101, 3'b101, 3'b010, 1'b0};
    tbl[6]  = '{3'b101, 3'b101, 3'b000, 1'b0};
    tbl[7]  = '{3'b101, 3'b101, 3'b000, 1'b0};
    tbl[8]  = '{3'b101, 3'b101, 3'b000, 1'b0};
    tbl[9]  = '{3'b101, 3'b101, 3'b000, 1'b0};
    tbl[10] = '{3'b111, 3'b101, 3'b000, 1'b0};
    tbl[11] = '{3'b111, 3'b101, 3'b000, 1'b0};
    tbl[12] = '{3'b111, 3'b101, 3'b000, 1'b1};
    tbl[13] = '{3'b111, 3'b101, 3'b000, 1'b1};
    tbl[14] = '{3'b111, 3'b101, 3'b000, 1'b1};
    tbl[15] = '{3'b111, 3'b111, 3'b000, 1'b0};
    tbl[16] = '{3'b111, 3'b111, 3'b000, 1'b0};
    tbl[17] = '{3'b111, 3'b111, 3'b000, 1'b0};

    rst = 1'b0;
    raw = 3'b111;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {stand, hit, deal}, 3'b111);
    check("reset_pulse", press_pulse, 3'b000);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Clean hit press of 10 clocks, then release
    for (int k = 0; k < 18; k++) begin
      step(tbl[k].raw);
      check("tbl_out", {stand, hit, deal}, tbl[k].out);
      check("tbl_pulse", press_pulse, tbl[k].pulse);
      check("tbl_busy", busy, tbl[k].busy);
    end

    // Glitch: deal low for 2 clocks only
    n_low = 0; n_pulse = 0; saw_busy = 0;
    for (int t = 0; t < 10; t++) begin
      step(t < 2 ? 3'b110 : 3'b111);
      if (!deal) n_low++;
      if (press_pulse != 3'b000) n_pulse++;
      if (busy) saw_busy = 1;
    end
    check("glitch_deal_low", n_low, 0);
    check("glitch_pulse", n_pulse, 0);
    check("glitch_busy_seen", saw_busy, 1);

    // Bounce: stand toggles for 8 clocks then holds low from clock 9
    first_fall = 0; n_pulse = 0;
    for (int t = 1; t <= 20; t++) begin
      step((t <= 8 && (t % 2) == 0) ? 3'b111 : 3'b011);
      if (!stand && first_fall == 0) first_fall = t;
      if (press_pulse[2]) n_pulse++;
    end
    check("bounce_fall_edge", first_fall, 9 + D + 1);
    check("bounce_strobes", n_pulse, 1);
    for (int t = 0; t < 10; t++) step(3'b111);

    // Seed hold: deal low 300 clocks
    n_low = 0; first_fall = 0; n_pulse = 0;
    for (int t = 1; t <= 312; t++) begin
      step(t <= 300 ? 3'b110 : 3'b111);
      if (!deal) n_low++;
      if (!deal && first_fall == 0) first_fall = t;
      if (press_pulse[0]) n_pulse++;
    end
    check("seed_low_cycles", n_low, 300);
    check("seed_first_low", first_fall, D + 2);
    check("seed_strobes", n_pulse, 1);

    // Simultaneous deal+hit; deal released after 10 clocks, hit after 20
    n_low = 0; n_low2 = 0; n_pulse = 0; n_pulse2 = 0; p_at = 3'b000;
    for (int t = 1; t <= 34; t++) begin
      step(t <= 10 ? 3'b100 : (t <= 20 ? 3'b101 : 3'b111));
      if (!deal) n_low++;
      if (!hit) n_low2++;
      if (t == D + 2) p_at = press_pulse;
      if (press_pulse[0]) n_pulse++;
      if (press_pulse[1]) n_pulse2++;
    end
    check("simul_deal_low", n_low, 10);
    check("simul_deal_strobes", n_pulse, 1);
`ifdef BUTTON_LOCKOUT_EN
    check("lock_pulse_at_fall", p_at, 3'b001);
    check("lock_hit_low", n_low2, 0);
    check("lock_hit_strobes", n_pulse2, 0);
`else
    check("simul_pulse_at_fall", p_at, 3'b011);
    check("simul_hit_low", n_low2, 20);
    check("simul_hit_strobes", n_pulse2, 1);
`endif

    // Reset while deal is held, then re-debounce after reset release
    for (int t = 0; t < 8; t++) step(3'b110);
    check("pre_reset_deal", deal, 1'b0);
    rst = 1'b0;
    #1;
    check("async_reset_out", {stand, hit, deal}, 3'b111);
    check("async_reset_busy", busy, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    first_fall = 0; n_pulse = 0;
    for (int t = 1; t <= 10; t++) begin
      step(3'b110);
      if (!deal && first_fall == 0) first_fall = t;
      if (press_pulse[0]) n_pulse++;
    end
    check("post_reset_fall_edge", first_fall, D + 2);
    check("post_reset_strobes", n_pulse, 1);
    for (int t = 0; t < 10; t++) step(3'b111);

    // Randomized stimulus, mostly holding with occasional flips
    r_rand = 3'b111;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 5) == 0) r_rand[i] = ~r_rand[i];
      end
      step(r_rand);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
